mem_tg_csr_regs: RTL and testbench
==================================

# mem_tg_csr_regs

Memory traffic-generator CSR register file. Avalon-MM slave that consumes the CSR accesses produced by the PCIe-TLP-to-CSR bridge, holds a DFH, scratch, control and status registers, and issues start/abort pulses to the traffic-generator core. Reads are pipelined with fixed latency; writes get a one-cycle write response.

## Interface
- `ADDR_W`, 18, AVMM byte-address width
- `DATA_W`, 64, AVMM data width; only 64 is supported
- `DFH_VALUE`, 64'h0, constant returned at offset 0x00
- `clk` in 1: sole clock
- `rst` in 1: synchronous, active-high reset
- `avmm_address` in ADDR_W: byte address; register index = address[7:3], bits [2:0] ignored
- `avmm_read` in 1: read request
- `avmm_write` in 1: write request
- `avmm_writedata` in 64: write data
- `avmm_byteenable` in 8: per-byte write enable
- `avmm_waitrequest` out 1: slave stall
- `avmm_readdata` out 64: read data
- `avmm_readdatavalid` out 1: read data strobe
- `avmm_writeresponsevalid` out 1: write completion strobe
- `tg_busy`, `tg_pass`, `tg_fail` in 1 each: core status
- `tg_start` out 1: one-cycle start pulse
- `tg_abort` out 1: one-cycle abort pulse
- `tg_loop_cnt` out 16: loop count to core

## Operation
- Register map; address[ADDR_W-1:8] nonzero = unmapped:
  - 0x00 DFH: RO, DFH_VALUE
  - 0x08 SCRATCH: RW, reset 0
  - 0x10 CTRL: bit0 START (W1 pulse, reads 0), bit1 ABORT (W1 pulse, reads 0), [31:16] LOOP_CNT RW (reset 0, drives tg_loop_cnt), all other bits read 0
  - 0x18 STATUS: RO; bit0 tg_busy, bit1 tg_pass, bit2 tg_fail (sampled), bit31 PROTO_ERR sticky; write with byteenable[3]=1 and writedata[31]=1 clears PROTO_ERR
  - 0x20 ACC_CNT: access counter (see Configuration)
- Unmapped: reads return 0; writes are dropped but still produce a writeresponsevalid.
- Writes merge per byte under avmm_byteenable. START/ABORT act only when byteenable[0]=1.
- START while tg_busy=1 (as sampled in the accept cycle) is ignored; no pulse.
- START and ABORT in the same write: ABORT pulses, START is dropped.
- Read and write asserted together: the write is performed; the read is dropped (no readdatavalid); PROTO_ERR is set.
- Access is accepted when (read|write) && !waitrequest.

## Timing
- Reset: all outputs 0 except avmm_waitrequest=1. waitrequest stays 1 while rst=1 and for one cycle after rst deasserts, then is held at 0.
- Read accepted in cycle T -> avmm_readdatavalid=1 with data in T+2. Fully pipelined, so one read per cycle sustains. readdata is 0 whenever readdatavalid=0.
- Write accepted in cycle T -> register updated at end of T; avmm_writeresponsevalid=1 in T+1; tg_start/tg_abort high in T+1 only.
- A read at T+1 of a register written at T returns the new value.
- STATUS read data is sampled in the accept cycle.
- rst asserted mid-operation: in-flight reads and write responses are discarded. No readdatavalid or writeresponsevalid is issued after the reset edge.

## Configuration
- `MEM_TG_CSR_ACC_CNT_EN` defined:
  - 0x20 is a 64-bit counter of accepted reads and writes, reset 0.
  - Saturates at all-ones.
  - Any write to 0x20 clears it, and that write is not counted.
  - A read of 0x20 returns the count before that read.
- Not defined: no counter logic; 0x20 reads 0 and writes are ignored.

## Test plan
- Reset release: waitrequest=1 during rst and 1 cycle after, then 0; read 0x00 with DFH_VALUE=64'hA5 -> readdatavalid 2 cycles later, data 0xA5.
- SCRATCH byte merge: write 0x08 = 64'h1122334455667788, be=8'hFF; then write 0x08 = 64'hFFFF_FFFF_FFFF_FFFF, be=8'h0F; read -> 64'h11223344FFFFFFFF.
- CTRL: write 0x10 = 0x0005_0001 with tg_busy=0 -> tg_start high exactly 1 cycle, tg_loop_cnt=5, readback 0x0005_0000. Same write with tg_busy=1 -> no pulse. Write 0x3 -> tg_abort pulse only.
- Back-to-back reads of 0x00, 0x08, 0x18, 0x40 on 4 consecutive cycles -> 4 consecutive readdatavalid cycles, in order; 0x40 returns 0.
- Read and write asserted together on 0x08 -> write applied, no readdatavalid, STATUS bit31=1; then write 0x18 with bit31=1, be=8'h0F -> bit31 cleared.
- With MEM_TG_CSR_ACC_CNT_EN: 3 accesses then read 0x20 -> 3; write 0x20 then read 0x20 -> 0. Without the macro -> 0x20 always reads 0.

Source files
------------

// File: rtl/mem_tg_csr_regs.sv
// Traffic-generator CSR block: DFH, scratch, control and status registers behind an AVMM slave.
// Optional access counter at 0x20 is built when MEM_TG_CSR_ACC_CNT_EN is defined.
module mem_tg_csr_regs #(
    parameter int          ADDR_W    = 18,
    parameter int          DATA_W    = 64,
    parameter logic [63:0] DFH_VALUE = 64'h0
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [ADDR_W-1:0]   avmm_address,
    input  logic                avmm_read,
    input  logic                avmm_write,
    input  logic [DATA_W-1:0]   avmm_writedata,
    input  logic [DATA_W/8-1:0] avmm_byteenable,
    output logic                avmm_waitrequest,
    output logic [DATA_W-1:0]   avmm_readdata,
    output logic                avmm_readdatavalid,
    output logic                avmm_writeresponsevalid,
    input  logic                tg_busy,
    input  logic                tg_pass,
    input  logic                tg_fail,
    output logic                tg_start,
    output logic                tg_abort,
    output logic [15:0]         tg_loop_cnt
);

    localparam int         BE_W     = DATA_W / 8;
    localparam logic [4:0] IDX_DFH  = 5'd0;
    localparam logic [4:0] IDX_SCR  = 5'd1;
    localparam logic [4:0] IDX_CTRL = 5'd2;
    localparam logic [4:0] IDX_STAT = 5'd3;
    localparam logic [4:0] IDX_ACC  = 5'd4;

    logic              wait_q;
    logic              acc_any, acc_wr, acc_rd, acc_both;
    logic              mapped;
    logic [4:0]        idx;
    logic              hit_scr, hit_ctrl, hit_stat, hit_acc;
    logic [DATA_W-1:0] be_mask;
    logic [DATA_W-1:0] scratch_q;
    logic [15:0]       loop_q;
    logic              proto_err_q;
    logic              start_q, abort_q, wresp_q;
    logic [DATA_W-1:0] rd_data;
    logic [DATA_W-1:0] status_word;
    logic              rd_v1, rd_v2;
    logic [DATA_W-1:0] rd_d1, rd_d2;
    logic              unused_addr_lsb;

    assign unused_addr_lsb = ^avmm_address[2:0];

    assign acc_any  = (avmm_read | avmm_write) & ~wait_q;
    assign acc_wr   = avmm_write & ~wait_q;
    assign acc_rd   = avmm_read & ~avmm_write & ~wait_q;
    assign acc_both = avmm_read & avmm_write & ~wait_q;

    assign mapped   = (avmm_address[ADDR_W-1:8] == '0);
    assign idx      = avmm_address[7:3];
    assign hit_scr  = mapped && (idx == IDX_SCR);
    assign hit_ctrl = mapped && (idx == IDX_CTRL);
    assign hit_stat = mapped && (idx == IDX_STAT);
    assign hit_acc  = mapped && (idx == IDX_ACC);

    always_comb begin
        be_mask = '0;
        for (int i = 0; i < BE_W; i++) begin
            be_mask[i*8 +: 8] = {8{avmm_byteenable[i]}};
        end
    end

    // Slave stalls through reset and for exactly one cycle after it drops.
    always_ff @(posedge clk) begin
        if (rst) wait_q <= 1'b1;
        else     wait_q <= 1'b0;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            scratch_q   <= '0;
            loop_q      <= '0;
            proto_err_q <= 1'b0;
            start_q     <= 1'b0;
            abort_q     <= 1'b0;
            wresp_q     <= 1'b0;
        end else begin
            wresp_q <= acc_wr;
            start_q <= acc_wr && hit_ctrl && avmm_byteenable[0] && avmm_writedata[0]
                       && !avmm_writedata[1] && !tg_busy;
            abort_q <= acc_wr && hit_ctrl && avmm_byteenable[0] && avmm_writedata[1];
            if (acc_wr && hit_scr)
                scratch_q <= (scratch_q & ~be_mask) | (avmm_writedata & be_mask);
            if (acc_wr && hit_ctrl) begin
                if (avmm_byteenable[2]) loop_q[7:0]  <= avmm_writedata[23:16];
                if (avmm_byteenable[3]) loop_q[15:8] <= avmm_writedata[31:24];
            end
            // A fresh protocol error outranks a simultaneous clear.
            if (acc_both)
                proto_err_q <= 1'b1;
            else if (acc_wr && hit_stat && avmm_byteenable[3] && avmm_writedata[31])
                proto_err_q <= 1'b0;
        end
    end

`ifdef MEM_TG_CSR_ACC_CNT_EN
    logic [63:0] acc_cnt_q;

    always_ff @(posedge clk) begin
        if (rst)
            acc_cnt_q <= '0;
        else if (acc_wr && hit_acc)
            acc_cnt_q <= '0;
        else if (acc_any && (acc_cnt_q != '1))
            acc_cnt_q <= acc_cnt_q + 64'd1;
    end
`else
    logic unused_acc;
    assign unused_acc = acc_any ^ hit_acc;
`endif

    assign status_word = {32'b0, proto_err_q, 28'b0, tg_fail, tg_pass, tg_busy};

    always_comb begin
        rd_data = '0;
        if (mapped) begin
            case (idx)
                IDX_DFH:  rd_data = DFH_VALUE;
                IDX_SCR:  rd_data = scratch_q;
                IDX_CTRL: rd_data = {32'b0, loop_q, 16'b0};
                IDX_STAT: rd_data = status_word;
`ifdef MEM_TG_CSR_ACC_CNT_EN
                IDX_ACC:  rd_data = acc_cnt_q;
`endif
                default:  rd_data = '0;
            endcase
        end
    end

    // Two-stage read pipeline gives fixed latency of two cycles.
    always_ff @(posedge clk) begin
        if (rst) begin
            rd_v1 <= 1'b0;
            rd_d1 <= '0;
            rd_v2 <= 1'b0;
            rd_d2 <= '0;
        end else begin
            rd_v1 <= acc_rd;
            rd_d1 <= acc_rd ? rd_data : '0;
            rd_v2 <= rd_v1;
            rd_d2 <= rd_v1 ? rd_d1 : '0;
        end
    end

    assign avmm_waitrequest        = wait_q;
    assign avmm_readdata           = rd_d2;
    assign avmm_readdatavalid      = rd_v2;
    assign avmm_writeresponsevalid = wresp_q;
    assign tg_start                = start_q;
    assign tg_abort                = abort_q;
    assign tg_loop_cnt             = loop_q;

endmodule

// File: tb/tb_mem_tg_csr_regs.sv
// Directed bench for mem_tg_csr_regs: vector table plus hand-written multi-cycle sequences.
module tb_mem_tg_csr_regs;

    logic        clk = 1'b0;
    logic        rst;
    logic [17:0] avmm_address;
    logic        avmm_read, avmm_write;
    logic [63:0] avmm_writedata;
    logic [7:0]  avmm_byteenable;
    logic        avmm_waitrequest;
    logic [63:0] avmm_readdata;
    logic        avmm_readdatavalid, avmm_writeresponsevalid;
    logic        tg_busy, tg_pass, tg_fail;
    logic        tg_start, tg_abort;
    logic [15:0] tg_loop_cnt;

    int n_pass = 0;
    int n_total = 0;

`ifdef MEM_TG_CSR_ACC_CNT_EN
    localparam logic [63:0] EXP_CNT = 64'd3;
`else
    localparam logic [63:0] EXP_CNT = 64'd0;
`endif

    always #5 clk = ~clk;

    mem_tg_csr_regs #(.ADDR_W(18), .DATA_W(64), .DFH_VALUE(64'hA5)) dut (
        .clk                     (clk),
        .rst                     (rst),
        .avmm_address            (avmm_address),
        .avmm_read               (avmm_read),
        .avmm_write              (avmm_write),
        .avmm_writedata          (avmm_writedata),
        .avmm_byteenable         (avmm_byteenable),
        .avmm_waitrequest        (avmm_waitrequest),
        .avmm_readdata           (avmm_readdata),
        .avmm_readdatavalid      (avmm_readdatavalid),
        .avmm_writeresponsevalid (avmm_writeresponsevalid),
        .tg_busy                 (tg_busy),
        .tg_pass                 (tg_pass),
        .tg_fail                 (tg_fail),
        .tg_start                (tg_start),
        .tg_abort                (tg_abort),
        .tg_loop_cnt             (tg_loop_cnt)
    );

    typedef struct {
        bit          is_wr;
        logic [17:0] addr;
        logic [63:0] wdata;
        logic [7:0]  be;
        logic [2:0]  stat;      // {fail, pass, busy}
        logic [63:0] exp_rd;
        bit          exp_start;
        bit          exp_abort;
        logic [15:0] exp_loop;
        string       name;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t mk(bit w, logic [17:0] a, logic [63:0] d, logic [7:0] be,
                                logic [2:0] st, logic [63:0] er, bit es, bit ea,
                                logic [15:0] el, string nm);
        vec_t v;
        v.is_wr = w; v.addr = a; v.wdata = d; v.be = be; v.stat = st;
        v.exp_rd = er; v.exp_start = es; v.exp_abort = ea; v.exp_loop = el; v.name = nm;
        return v;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    task automatic idle();
        avmm_read = 1'b0; avmm_write = 1'b0;
        avmm_address = '0; avmm_writedata = '0; avmm_byteenable = '0;
    endtask

    task automatic wr(input logic [17:0] a, input logic [63:0] d, input logic [7:0] be,
                      input string nm);
        avmm_address = a; avmm_writedata = d; avmm_byteenable = be; avmm_write = 1'b1;
        tick();
        idle();
        chk({nm, "_wresp"}, 64'(avmm_writeresponsevalid), 64'd1);
    endtask

    task automatic rd_chk(input logic [17:0] a, input logic [63:0] exp, input string nm);
        avmm_address = a; avmm_read = 1'b1;
        tick();
        idle();
        tick();
        chk({nm, "_rdv"}, 64'(avmm_readdatavalid), 64'd1);
        chk({nm, "_data"}, avmm_readdata, exp);
    endtask

    task automatic do_vec(input vec_t v);
        {tg_fail, tg_pass, tg_busy} = v.stat;
        avmm_address = v.addr;
        if (v.is_wr) begin
            avmm_writedata = v.wdata; avmm_byteenable = v.be; avmm_write = 1'b1;
            tick();
            idle();
            chk({v.name, "_wresp"}, 64'(avmm_writeresponsevalid), 64'd1);
            chk({v.name, "_start"}, 64'(tg_start), 64'(v.exp_start));
            chk({v.name, "_abort"}, 64'(tg_abort), 64'(v.exp_abort));
            chk({v.name, "_loop"}, 64'(tg_loop_cnt), 64'(v.exp_loop));
            tick();
            chk({v.name, "_pulse_end"}, 64'({tg_start, tg_abort, avmm_writeresponsevalid}), 64'd0);
        end else begin
            avmm_read = 1'b1;
            tick();
            idle();
            chk({v.name, "_early_rdv"}, 64'(avmm_readdatavalid), 64'd0);
            tick();
            chk({v.name, "_rdv"}, 64'(avmm_readdatavalid), 64'd1);
            chk({v.name, "_data"}, avmm_readdata, v.exp_rd);
        end
        {tg_fail, tg_pass, tg_busy} = 3'b000;
    endtask

    logic [17:0] b2b_addr [4];
    logic [63:0] b2b_exp  [4];

    initial begin
        rst = 1'b1;
        tg_busy = 1'b0; tg_pass = 1'b0; tg_fail = 1'b0;
        idle();

        vecs.push_back(mk(0, 18'h00,  64'h0, 8'h00, 3'b000, 64'hA5, 0, 0, 16'd0, "dfh_rd"));
        vecs.push_back(mk(1, 18'h08,  64'h1122334455667788, 8'hFF, 3'b000, 0, 0, 0, 16'd0, "scr_wr_full"));
        vecs.push_back(mk(1, 18'h08,  64'hFFFF_FFFF_FFFF_FFFF, 8'h0F, 3'b000, 0, 0, 0, 16'd0, "scr_wr_low"));
        vecs.push_back(mk(0, 18'h08,  64'h0, 8'h00, 3'b000, 64'h11223344FFFFFFFF, 0, 0, 0, "scr_merge_rd"));
        vecs.push_back(mk(1, 18'h10,  64'h0005_0001, 8'hFF, 3'b000, 0, 1, 0, 16'd5, "ctrl_start"));
        vecs.push_back(mk(0, 18'h10,  64'h0, 8'h00, 3'b000, 64'h0005_0000, 0, 0, 0, "ctrl_rd"));
        vecs.push_back(mk(1, 18'h10,  64'h0005_0001, 8'hFF, 3'b001, 0, 0, 0, 16'd5, "ctrl_start_busy"));
        vecs.push_back(mk(1, 18'h10,  64'h3, 8'hFF, 3'b000, 0, 0, 1, 16'd0, "ctrl_abort_start"));
        vecs.push_back(mk(1, 18'h10,  64'h0007_0001, 8'hFE, 3'b000, 0, 0, 0, 16'd7, "ctrl_start_no_be0"));
        vecs.push_back(mk(0, 18'h10,  64'h0, 8'h00, 3'b000, 64'h0007_0000, 0, 0, 0, "ctrl_rd2"));
        vecs.push_back(mk(0, 18'h18,  64'h0, 8'h00, 3'b001, 64'h1, 0, 0, 0, "stat_busy"));
        vecs.push_back(mk(0, 18'h18,  64'h0, 8'h00, 3'b110, 64'h6, 0, 0, 0, "stat_pass_fail"));
        vecs.push_back(mk(1, 18'h100, 64'h1234, 8'hFF, 3'b000, 0, 0, 0, 16'd7, "unmapped_wr"));
        vecs.push_back(mk(0, 18'h100, 64'h0, 8'h00, 3'b000, 64'h0, 0, 0, 0, "unmapped_rd"));
        vecs.push_back(mk(1, 18'h28,  64'hFFFF_FFFF_FFFF_FFFF, 8'hFF, 3'b000, 0, 0, 0, 16'd7, "idx5_wr"));
        vecs.push_back(mk(0, 18'h28,  64'h0, 8'h00, 3'b000, 64'h0, 0, 0, 0, "idx5_rd"));
        vecs.push_back(mk(0, 18'h0C,  64'h0, 8'h00, 3'b000, 64'h11223344FFFFFFFF, 0, 0, 0, "scr_lsb_ignored"));
        vecs.push_back(mk(1, 18'h00,  64'hFFFF_FFFF_FFFF_FFFF, 8'hFF, 3'b000, 0, 0, 0, 16'd7, "dfh_wr"));
        vecs.push_back(mk(0, 18'h04,  64'h0, 8'h00, 3'b000, 64'hA5, 0, 0, 0, "dfh_ro_rd"));
        vecs.push_back(mk(1, 18'h10,  64'h0000_FFFF_0003_0003, 8'h0F, 3'b000, 0, 0, 1, 16'd3, "ctrl_both_loop3"));
        vecs.push_back(mk(0, 18'h10,  64'h0, 8'h00, 3'b000, 64'h0003_0000, 0, 0, 0, "ctrl_rd3"));

        // Reset state and release.
        tick(); tick(); tick();
        chk("rst_wait", 64'(avmm_waitrequest), 64'd1);
        chk("rst_outs", 64'({avmm_readdatavalid, avmm_writeresponsevalid, tg_start, tg_abort}), 64'd0);
        chk("rst_rdata", avmm_readdata, 64'd0);
        chk("rst_loop", 64'(tg_loop_cnt), 64'd0);
        rst = 1'b0;
        chk("rel_wait_hold", 64'(avmm_waitrequest), 64'd1);
        tick();
        chk("rel_wait_low", 64'(avmm_waitrequest), 64'd0);

        foreach (vecs[i]) do_vec(vecs[i]);

        // Back-to-back reads: four consecutive valids in issue order.
        b2b_addr[0] = 18'h00; b2b_exp[0] = 64'hA5;
        b2b_addr[1] = 18'h08; b2b_exp[1] = 64'h11223344FFFFFFFF;
        b2b_addr[2] = 18'h18; b2b_exp[2] = 64'h0;
        b2b_addr[3] = 18'h40; b2b_exp[3] = 64'h0;
        for (int k = 0; k < 6; k++) begin
            if (k < 4) begin
                avmm_address = b2b_addr[k]; avmm_read = 1'b1;
            end else begin
                idle();
            end
            tick();
            if (k == 0 || k == 5) begin
                chk($sformatf("b2b_gap%0d_rdv", k), 64'(avmm_readdatavalid), 64'd0);
                chk($sformatf("b2b_gap%0d_data", k), avmm_readdata, 64'd0);
            end else begin
                chk($sformatf("b2b%0d_rdv", k - 1), 64'(avmm_readdatavalid), 64'd1);
                chk($sformatf("b2b%0d_data", k - 1), avmm_readdata, b2b_exp[k-1]);
            end
        end

        // Read and write together: write wins, read dropped, PROTO_ERR set then cleared.
        avmm_address = 18'h08; avmm_writedata = 64'hDEAD_BEEF; avmm_byteenable = 8'hFF;
        avmm_read = 1'b1; avmm_write = 1'b1;
        tick();
        idle();
        chk("conf_wresp", 64'(avmm_writeresponsevalid), 64'd1);
        tick();
        chk("conf_no_rdv", 64'(avmm_readdatavalid), 64'd0);
        tick();
        chk("conf_no_rdv_late", 64'(avmm_readdatavalid), 64'd0);
        rd_chk(18'h18, 64'h8000_0000, "conf_proto_set");
        rd_chk(18'h08, 64'hDEAD_BEEF, "conf_write_applied");
        wr(18'h18, 64'h8000_0000, 8'h0F, "proto_clr");
        rd_chk(18'h18, 64'h0, "proto_cleared");

        // Reset mid-read discards the in-flight response.
        avmm_address = 18'h08; avmm_read = 1'b1;
        tick();
        idle();
        rst = 1'b1;
        tick();
        chk("midrst_rdv", 64'(avmm_readdatavalid), 64'd0);
        chk("midrst_wait", 64'(avmm_waitrequest), 64'd1);
        chk("midrst_loop", 64'(tg_loop_cnt), 64'd0);
        tick();
        chk("midrst_rdv2", 64'(avmm_readdatavalid), 64'd0);
        rst = 1'b0;
        chk("midrst_rel_wait", 64'(avmm_waitrequest), 64'd1);
        tick();
        chk("midrst_rel_low", 64'(avmm_waitrequest), 64'd0);
        rd_chk(18'h08, 64'h0, "midrst_scr_cleared");

        // Access counter: clearing write is not counted, read returns pre-read count.
        wr(18'h20, 64'h0, 8'hFF, "cnt_clr");
        wr(18'h08, 64'h55, 8'hFF, "cnt_a1");
        rd_chk(18'h00, 64'hA5, "cnt_a2");
        rd_chk(18'h08, 64'h55, "cnt_a3");
        rd_chk(18'h20, EXP_CNT, "cnt_three");
        wr(18'h20, 64'hFFFF, 8'hFF, "cnt_clr2");
        rd_chk(18'h20, 64'h0, "cnt_zero");

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
